multi_decade_down_counter: RTL and testbench

Three-digit (000–999) loadable BCD down counter with terminal-count detection. It is the countdown counterpart of the team's cascaded BCD up counter and provides countdown timers and event budgets in the same display and counter datapath. A parallel load presets the count, `enable` decrements it one step per cycle, and `done` flags arrival at 000. An optional compile-time feature reloads the count automatically to make a periodic timer.

---
 rtl/multi_decade_down_counter.sv | 92 +++++++++
 tb/tb_multi_decade_down_counter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/multi_decade_down_counter.sv
// Three-digit loadable BCD down counter with terminal-count pulse.
// Define MULTI_DECADE_DOWN_COUNTER_AUTORELOAD_EN for periodic auto-reload at 000.
module multi_decade_down_counter #(
    parameter logic [11:0] RESET_COUNT = 12'h000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       load,
    input  logic [3:0] load_hundreds,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_ones,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       zero,
    output logic       done
);

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    logic [3:0] dec_h;
    logic [3:0] dec_t;
    logic [3:0] dec_o;
    logic       dec_zero;
    logic [3:0] ld_h;
    logic [3:0] ld_t;
    logic [3:0] ld_o;

`ifdef MULTI_DECADE_DOWN_COUNTER_AUTORELOAD_EN
    logic [11:0] reload;
`endif

    assign ld_h = clamp9(load_hundreds);
    assign ld_t = clamp9(load_tens);
    assign ld_o = clamp9(load_ones);

    assign zero     = (hundreds == 4'd0) && (tens == 4'd0) && (ones == 4'd0);
    assign dec_zero = (hundreds == 4'd0) && (tens == 4'd0) && (ones == 4'd1);

    // Ripple borrow across the decades; only used while count is nonzero.
    always_comb begin
        dec_o = ones - 4'd1;
        dec_t = tens;
        dec_h = hundreds;
        if (ones == 4'd0) begin
            dec_o = 4'd9;
            dec_t = tens - 4'd1;
            if (tens == 4'd0) begin
                dec_t = 4'd9;
                dec_h = hundreds - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hundreds <= RESET_COUNT[11:8];
            tens     <= RESET_COUNT[7:4];
            ones     <= RESET_COUNT[3:0];
            done     <= 1'b0;
`ifdef MULTI_DECADE_DOWN_COUNTER_AUTORELOAD_EN
            reload   <= RESET_COUNT;
`endif
        end else if (load) begin
            hundreds <= ld_h;
            tens     <= ld_t;
            ones     <= ld_o;
            done     <= 1'b0;
`ifdef MULTI_DECADE_DOWN_COUNTER_AUTORELOAD_EN
            reload   <= {ld_h, ld_t, ld_o};
`endif
        end else if (enable && !zero) begin
            hundreds <= dec_h;
            tens     <= dec_t;
            ones     <= dec_o;
            done     <= dec_zero;
        end else if (enable) begin
`ifdef MULTI_DECADE_DOWN_COUNTER_AUTORELOAD_EN
            hundreds <= reload[11:8];
            tens     <= reload[7:4];
            ones     <= reload[3:0];
`endif
            done     <= 1'b0;
        end else begin
            done     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_decade_down_counter.sv
// Self-checking bench for multi_decade_down_counter: vector table,
// hand sequences and randomized traffic against an integer count model.
module tb_multi_decade_down_counter;

    localparam logic [11:0] RC = 12'h000;

    logic       clk = 1'b0;
    logic       reset, enable, load;
    logic [3:0] lh, lt, lo;
    logic [3:0] hundreds, tens, ones;
    logic       zero, done;

    int checks   = 0;
    int failures = 0;

    int m_cnt;
    int m_rel;
    bit m_done;

    always #5 clk = ~clk;

    multi_decade_down_counter #(.RESET_COUNT(RC)) dut (
        .clk(clk), .reset(reset), .enable(enable), .load(load),
        .load_hundreds(lh), .load_tens(lt), .load_ones(lo),
        .hundreds(hundreds), .tens(tens), .ones(ones),
        .zero(zero), .done(done)
    );

    function automatic int clampv(logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    function automatic logic [11:0] to_bcd(int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int bcd_val(logic [11:0] b);
        return clampv(b[11:8]) * 100 + clampv(b[7:4]) * 10 + clampv(b[3:0]);
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, compare DUT to model.
    task automatic cycle(bit r, bit l, bit e, logic [3:0] h, logic [3:0] t, logic [3:0] o);
        reset = r; load = l; enable = e; lh = h; lt = t; lo = o;
        @(posedge clk);
        if (r) begin
            m_cnt = bcd_val(RC); m_rel = m_cnt; m_done = 0;
        end else if (l) begin
            m_cnt = clampv(h) * 100 + clampv(t) * 10 + clampv(o);
            m_rel = m_cnt; m_done = 0;
        end else if (e && m_cnt != 0) begin
            m_cnt = m_cnt - 1; m_done = (m_cnt == 0);
        end else if (e) begin
`ifdef MULTI_DECADE_DOWN_COUNTER_AUTORELOAD_EN
            m_cnt = m_rel;
`endif
            m_done = 0;
        end else begin
            m_done = 0;
        end
        #1;
        check("model_count", {hundreds, tens, ones}, to_bcd(m_cnt));
        check("model_zero", zero, m_cnt == 0);
        check("model_done", done, m_done);
    endtask

    typedef struct {
        string      name;
        bit         r, l, e;
        logic [3:0] h, t, o;
        logic [11:0] exp_cnt;
        bit         exp_zero, exp_done;
    } vec_t;

    vec_t vecs[$];

    initial begin
        reset = 1'b1; load = 1'b0; enable = 1'b0;
        lh = 4'd0; lt = 4'd0; lo = 4'd0;
        m_cnt = 0; m_rel = 0; m_done = 0;

        vecs.push_back('{"reset",       1,0,0, 4'd0,4'd0,4'd0, 12'h000,1,0});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{"sat_at_zero", 0,0,1, 4'd0,4'd0,4'd0, 12'h000,1,0});
        vecs.push_back('{"clamp_load",  0,1,0, 4'hC,4'd3,4'hF, 12'h939,0,0});
        vecs.push_back('{"load_100",    0,1,0, 4'd1,4'd0,4'd0, 12'h100,0,0});
        vecs.push_back('{"dbl_borrow",  0,0,1, 4'd0,4'd0,4'd0, 12'h099,0,0});
        vecs.push_back('{"load_wins",   0,1,1, 4'd0,4'd0,4'd5, 12'h005,0,0});
        vecs.push_back('{"dec_005",     0,0,1, 4'd0,4'd0,4'd0, 12'h004,0,0});
        vecs.push_back('{"hold",        0,0,0, 4'd0,4'd0,4'd0, 12'h004,0,0});
        vecs.push_back('{"load_001",    0,1,0, 4'd0,4'd0,4'd1, 12'h001,0,0});
        vecs.push_back('{"terminal",    0,0,1, 4'd0,4'd0,4'd0, 12'h000,1,1});
        vecs.push_back('{"done_drops",  0,0,0, 4'd0,4'd0,4'd0, 12'h000,1,0});
        vecs.push_back('{"load_000",    0,1,1, 4'd0,4'd0,4'd0, 12'h000,1,0});
        vecs.push_back('{"load_003",    0,1,0, 4'd0,4'd0,4'd3, 12'h003,0,0});
        vecs.push_back('{"dec_002",     0,0,1, 4'd0,4'd0,4'd0, 12'h002,0,0});
        vecs.push_back('{"dec_001",     0,0,1, 4'd0,4'd0,4'd0, 12'h001,0,0});
        vecs.push_back('{"reset_mid",   1,0,1, 4'd0,4'd0,4'd0, RC,     1,0});

        foreach (vecs[i]) begin
            cycle(vecs[i].r, vecs[i].l, vecs[i].e, vecs[i].h, vecs[i].t, vecs[i].o);
            check({vecs[i].name, "_count"}, {hundreds, tens, ones}, vecs[i].exp_cnt);
            check({vecs[i].name, "_zero"}, zero, vecs[i].exp_zero);
            check({vecs[i].name, "_done"}, done, vecs[i].exp_done);
        end

        // 100 enabled cycles from 100 reach 000 with a single done pulse.
        cycle(0, 1, 0, 4'd1, 4'd0, 4'd0);
        for (int i = 1; i <= 100; i++) begin
            cycle(0, 0, 1, 4'd0, 4'd0, 4'd0);
            if (i == 1) check("seq100_first", {hundreds, tens, ones}, 12'h099);
            if (i == 99) check("seq100_pre_done", done, 1'b0);
            if (i == 100) begin
                check("seq100_end", {hundreds, tens, ones}, 12'h000);
                check("seq100_done", done, 1'b1);
            end
        end
        cycle(0, 0, 1, 4'd0, 4'd0, 4'd0);
        check("seq100_done_once", done, 1'b0);

`ifdef MULTI_DECADE_DOWN_COUNTER_AUTORELOAD_EN
        begin
            logic [11:0] exp_seq [6];
            bit          exp_dn  [6];
            exp_seq = '{12'h001, 12'h000, 12'h002, 12'h001, 12'h000, 12'h002};
            exp_dn  = '{0, 1, 0, 0, 1, 0};
            cycle(0, 1, 0, 4'd0, 4'd0, 4'd2);
            for (int i = 0; i < 6; i++) begin
                cycle(0, 0, 1, 4'd0, 4'd0, 4'd0);
                check("reload_count", {hundreds, tens, ones}, exp_seq[i]);
                check("reload_done", done, exp_dn[i]);
            end
            cycle(0, 1, 0, 4'd0, 4'd0, 4'd0);
            for (int i = 0; i < 4; i++) begin
                cycle(0, 0, 1, 4'd0, 4'd0, 4'd0);
                check("reload_zero_count", {hundreds, tens, ones}, 12'h000);
                check("reload_zero_done", done, 1'b0);
            end
        end
`endif

        for (int i = 0; i < 4000; i++) begin
            bit r, l, e;
            logic [3:0] h, t, o;
            r = ($urandom % 97) == 0;
            l = ($urandom % 24) == 0;
            e = ($urandom % 5) != 0;
            h = ($urandom % 3 != 0) ? 4'd0 : 4'($urandom);
            t = ($urandom % 2 != 0) ? 4'd0 : 4'($urandom);
            o = 4'($urandom);
            cycle(r, l, e, h, t, o);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
